// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module : hazard_ctrl_if
//  Brief  : Hazard-control bundle between the ID/EX/MEM datapath and the sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             idex_memRead_i;
    logic [4:0]       idex_rt_i;
    logic             branch_i;
    logic             jump_i;
    logic             mem_req_i;
    logic             mem_ready_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_hold_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             timeout_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, idex_memRead_i, idex_rt_i,
               branch_i, jump_i, mem_req_i, mem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               pipe_hold_o, stall_cnt_o, timeout_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, idex_memRead_i, idex_rt_i,
               branch_i, jump_i, mem_req_i, mem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               pipe_hold_o, stall_cnt_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : hazard_ctrl
//  Brief  : 5-stage pipeline sequencer: load-use bubble, branch flush, memory-wait freeze.
//  Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_TIMEOUT = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_pipe_hold;

    // $0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_load_use = bus.idex_memRead_i && (bus.idex_rt_i != 5'd0) &&
                        ((bus.idex_rt_i == bus.id_rs_i) ||
                         (bus.id_uses_rt_i && (bus.idex_rt_i == bus.id_rt_i)));
    assign w_mem_stall = bus.mem_req_i && !bus.mem_ready_i;

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_hold   = 1'b0;

        if (w_mem_stall) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_hold  = 1'b1;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (bus.branch_i || bus.jump_i) begin
            w_ifid_flush = 1'b1;
        end

        // A completing wait falls through to the normal decode above
        if ((r_state == S_ERROR) || ((r_state == S_MEM_WAIT) && !bus.mem_ready_i)) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_bubble = 1'b0;
            w_pipe_hold   = 1'b1;
        end

        if (rst_i) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b0;
            w_idex_bubble = 1'b0;
            w_pipe_hold   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.mem_ready_i) begin
                        r_state <= S_RUN;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_ERROR: begin
                    r_state <= S_ERROR;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign bus.pc_write_o    = w_pc_write;
    assign bus.ifid_write_o  = w_ifid_write;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_bubble_o = w_idex_bubble;
    assign bus.pipe_hold_o   = w_pipe_hold;
    assign bus.stall_cnt_o   = rst_i ? '0 : r_stall_cnt;
    assign bus.timeout_o     = (r_state == S_ERROR) && !rst_i;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_hazard_ctrl
//  Brief  : Directed self-checking bench for hazard_ctrl.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = 31;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_cnt;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic memrd, input logic [4:0] xrt, input logic br,
                         input logic jmp, input logic req, input logic rdy);
        bus.id_rs_i        = rs;
        bus.id_rt_i        = rt;
        bus.id_uses_rt_i   = uses;
        bus.idex_memRead_i = memrd;
        bus.idex_rt_i      = xrt;
        bus.branch_i       = br;
        bus.jump_i         = jmp;
        bus.mem_req_i      = req;
        bus.mem_ready_i    = rdy;
    endtask

    task automatic tick(input logic stalled);
        @(posedge clk);
        #1;
        if (stalled && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b0) begin failures++; $display("FAIL reset_pc_write got=%b exp=0", bus.pc_write_o); end
        checks++; if (bus.ifid_write_o !== 1'b0 || bus.ifid_flush_o !== 1'b0) begin failures++; $display("FAIL reset_ifid got=%b%b exp=00", bus.ifid_write_o, bus.ifid_flush_o); end
        checks++; if (bus.stall_cnt_o !== 5'd0 || bus.timeout_o !== 1'b0) begin failures++; $display("FAIL reset_cnt_to got=%0d/%b exp=0/0", bus.stall_cnt_o, bus.timeout_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_normal;
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b1 || bus.ifid_write_o !== 1'b1) begin failures++; $display("FAIL normal_write got=%b%b exp=11", bus.pc_write_o, bus.ifid_write_o); end
        checks++; if ({bus.ifid_flush_o, bus.idex_bubble_o, bus.pipe_hold_o} !== 3'b000) begin failures++; $display("FAIL normal_ctrl got=%b%b%b exp=000", bus.ifid_flush_o, bus.idex_bubble_o, bus.pipe_hold_o); end
        tick(1'b0);
    endtask

    task automatic test_load_use;
        drive(5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0) begin failures++; $display("FAIL lu_write got=%b%b exp=00", bus.pc_write_o, bus.ifid_write_o); end
        checks++; if (bus.idex_bubble_o !== 1'b1 || bus.pipe_hold_o !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b hold=%b exp=1/0", bus.idex_bubble_o, bus.pipe_hold_o); end
        checks++; if (bus.stall_cnt_o !== 5'd0) begin failures++; $display("FAIL lu_cnt_before got=%0d exp=0", bus.stall_cnt_o); end
        tick(1'b1);
        drive(5'd3, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0) begin failures++; $display("FAIL lu_release got=%b bubble=%b exp=1/0", bus.pc_write_o, bus.idex_bubble_o); end
        checks++; if (bus.stall_cnt_o !== 5'(exp_cnt)) begin failures++; $display("FAIL lu_cnt_after got=%0d exp=%0d", bus.stall_cnt_o, exp_cnt); end
        tick(1'b0);
    endtask

    task automatic test_zero_reg;
        drive(5'd0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0) begin failures++; $display("FAIL zero_reg got=%b bubble=%b exp=1/0", bus.pc_write_o, bus.idex_bubble_o); end
        tick(1'b0);
    endtask

    task automatic test_uses_rt;
        drive(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b0 || bus.idex_bubble_o !== 1'b1) begin failures++; $display("FAIL sw_rt got=%b bubble=%b exp=0/1", bus.pc_write_o, bus.idex_bubble_o); end
        tick(1'b1);
        drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0) begin failures++; $display("FAIL addi_rt got=%b bubble=%b exp=1/0", bus.pc_write_o, bus.idex_bubble_o); end
        tick(1'b0);
    endtask

    task automatic test_branch_load_use;
        drive(5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.idex_bubble_o !== 1'b1 || bus.ifid_flush_o !== 1'b0 || bus.pc_write_o !== 1'b0) begin failures++; $display("FAIL br_lu got=b%b f%b p%b exp=b1 f0 p0", bus.idex_bubble_o, bus.ifid_flush_o, bus.pc_write_o); end
        tick(1'b1);
        drive(5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.ifid_flush_o !== 1'b1 || bus.pc_write_o !== 1'b1 || bus.idex_bubble_o !== 1'b0) begin failures++; $display("FAIL br_after got=f%b p%b b%b exp=f1 p1 b0", bus.ifid_flush_o, bus.pc_write_o, bus.idex_bubble_o); end
        tick(1'b0);
    endtask

    task automatic test_jump;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.ifid_flush_o !== 1'b1 || bus.ifid_write_o !== 1'b1) begin failures++; $display("FAIL jump got=f%b w%b exp=f1 w1", bus.ifid_flush_o, bus.ifid_write_o); end
        checks++; if (bus.stall_cnt_o !== 5'(exp_cnt)) begin failures++; $display("FAIL jump_cnt got=%0d exp=%0d", bus.stall_cnt_o, exp_cnt); end
        tick(1'b0);
    endtask

    task automatic test_mem_wait;
        for (int i = 0; i < 3; i++) begin
            drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checks++; if (bus.pipe_hold_o !== 1'b1 || bus.pc_write_o !== 1'b0 || bus.ifid_write_o !== 1'b0) begin failures++; $display("FAIL mw_hold[%0d] got=h%b p%b w%b exp=h1 p0 w0", i, bus.pipe_hold_o, bus.pc_write_o, bus.ifid_write_o); end
            tick(1'b1);
        end
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (bus.pipe_hold_o !== 1'b0 || bus.pc_write_o !== 1'b1 || bus.ifid_flush_o !== 1'b1) begin failures++; $display("FAIL mw_ready got=h%b p%b f%b exp=h0 p1 f1", bus.pipe_hold_o, bus.pc_write_o, bus.ifid_flush_o); end
        tick(1'b0);
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b1 || bus.stall_cnt_o !== 5'(exp_cnt)) begin failures++; $display("FAIL mw_back_run got=p%b cnt=%0d exp=p1 cnt=%0d", bus.pc_write_o, bus.stall_cnt_o, exp_cnt); end
        tick(1'b0);
    endtask

    task automatic test_timeout;
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            @(negedge clk);
            checks++; if (bus.pipe_hold_o !== 1'b1 || bus.timeout_o !== 1'b0) begin failures++; $display("FAIL to_wait[%0d] got=h%b t%b exp=h1 t0", i, bus.pipe_hold_o, bus.timeout_o); end
            tick(1'b1);
        end
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (bus.timeout_o !== 1'b1 || bus.pc_write_o !== 1'b0 || bus.pipe_hold_o !== 1'b1) begin failures++; $display("FAIL to_error[%0d] got=t%b p%b h%b exp=t1 p0 h1", i, bus.timeout_o, bus.pc_write_o, bus.pipe_hold_o); end
            tick(1'b1);
        end
        @(negedge clk);
        checks++; if (bus.stall_cnt_o !== 5'(exp_cnt) || exp_cnt != CNT_MAX) begin failures++; $display("FAIL cnt_saturate got=%0d exp=%0d", bus.stall_cnt_o, CNT_MAX); end
        tick(1'b1);
    endtask

    task automatic test_reset_clear;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.timeout_o !== 1'b0 || bus.stall_cnt_o !== 5'd0 || bus.pc_write_o !== 1'b0) begin failures++; $display("FAIL rst_clear got=t%b cnt=%0d p%b exp=t0 cnt=0 p0", bus.timeout_o, bus.stall_cnt_o, bus.pc_write_o); end
        tick(1'b0);
        rst = 1'b0;
        exp_cnt = 0;
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b1 || bus.timeout_o !== 1'b0) begin failures++; $display("FAIL rst_run got=p%b t%b exp=p1 t0", bus.pc_write_o, bus.timeout_o); end
        tick(1'b0);
    endtask

    task automatic test_abort_wait;
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1);
        tick(1'b1);
        #2;
        rst = 1'b1;
        drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        checks++; if (bus.pc_write_o !== 1'b1 || bus.pipe_hold_o !== 1'b0 || bus.stall_cnt_o !== 5'd0) begin failures++; $display("FAIL abort_wait got=p%b h%b cnt=%0d exp=p1 h0 cnt=0", bus.pc_write_o, bus.pipe_hold_o, bus.stall_cnt_o); end
        tick(1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        rst      = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset;
        test_normal;
        test_load_use;
        test_zero_reg;
        test_uses_rt;
        test_branch_load_use;
        test_jump;
        test_mem_wait;
        test_timeout;
        test_reset_clear;
        test_abort_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
